var_value_base: RTL and testbench
=================================

Name: var_value_base

Overview:
- Per-bin variable-state store: the "base" end of the clause value bus.
- Drives the packed variable values into the clause array and absorbs the implications and conflicts the clauses return.
- Sequences decide → settle → absorb, tracks a decision level per variable, and performs backtrack.
- One instance per bin; sits between the bin controller and the clause array.

Parameters:
- NUM_VARS_A_BIN, 8, variables per bin; one 3-bit field each.
- LEVEL_WIDTH, 8, decision-level width.
- SETTLE_CYCLES, 2, cycles to wait for the combinational clause array after every change; must be ≥ 1.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-low.
- load_i  in  1  load the initial bin values.
- load_value_i  in  NUM_VARS_A_BIN*3  initial values.
- decide_valid_i  in  1  decision request.
- decide_ready_o  out  1  decision accepted this cycle.
- decide_var_i  in  $clog2(NUM_VARS_A_BIN)  variable index.
- decide_value_i  in  2  2'b01 false, 2'b10 true.
- var_value_toclause_o  out  NUM_VARS_A_BIN*3  current values to the clauses.
- var_value_fromclause_i  in  NUM_VARS_A_BIN*3  OR-merged clause outputs.
- backtrack_valid_i  in  1  backtrack request.
- backtrack_level_i  in  LEVEL_WIDTH  level to return to.
- apply_backtrack_o  out  1  one-cycle pulse to the clauses.
- level_o  out  LEVEL_WIDTH  current decision level.
- busy_o  out  1  not in IDLE.
- conflict_o  out  1  conflict detected; held until backtrack.
- conflict_var_o  out  $clog2(NUM_VARS_A_BIN)  lowest conflicting variable index.
- all_assigned_o  out  1  every variable assigned and no conflict.

Behaviour:
- Field encoding, per variable {imp, val[1:0]}:
  - val 00 free, 01 false, 10 true, 11 conflict.
  - imp = 1 means the value was implied, not decided.
- Reset (rst == 0 at a posedge):
  - All fields 0, all levels 0, level_o = 0, state IDLE.
  - All outputs 0 except decide_ready_o = 0.
  - A reset mid-operation aborts immediately.
- FSM states: IDLE, SETTLE, ABSORB, CONFLICT, BACKTRACK.
- Priority in IDLE, highest first: load_i, backtrack_valid_i, decide_valid_i.
- IDLE:
  - decide_ready_o = 1.
  - load_i: copy load_value_i, clear levels, go to SETTLE.
  - decide_valid_i with a free target:
    - level_o increments, saturating at all-ones.
    - Write {0, decide_value_i} and record the level.
    - Go to SETTLE.
  - decide_valid_i with an assigned target: ignored, still handshaken; no state change.
- SETTLE: count SETTLE_CYCLES cycles, then go to ABSORB.
- ABSORB, evaluated per field in one cycle:
  - Incoming val 11 → conflict.
  - Incoming imp = 1 with val 01/10 on a free base variable → assign {1, val}, level = level_o, mark "new".
  - Incoming val opposite to a non-free base value → conflict.
  - Incoming equal to the base value → no action.
  - Transition: any conflict → CONFLICT (conflict takes precedence over new assignments); else any new → SETTLE; else → IDLE.
- CONFLICT:
  - conflict_o = 1; conflict_var_o = lowest conflicting index.
  - Wait for backtrack_valid_i; decide_valid_i is ignored.
- BACKTRACK, entered from IDLE or CONFLICT on backtrack_valid_i:
  - Clear every field whose level > backtrack_level_i.
  - level_o = backtrack_level_i.
  - Pulse apply_backtrack_o for exactly one cycle.
  - Clear conflict_o.
  - Go to SETTLE.
  - backtrack_level_i ≥ level_o → no fields cleared; the pulse is still issued.
- all_assigned_o is combinational: every val is 01/10 and conflict_o = 0.
- Latency: decision accept → first ABSORB = SETTLE_CYCLES + 1 cycles.

Optional Feature:
- Macro: VAR_BASE_IMP_COUNT_EN.
- Defined:
  - Adds output imp_count_o, 16 bits.
  - Counts implied assignments made in ABSORB: +popcount per cycle, saturating at 16'hFFFF.
  - Cleared by reset and by load_i.
- Undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- Reset, then load all zeros → var_value_toclause_o == 0, level_o == 0, decide_ready_o == 1 in IDLE.
- Decide var 1 = 2'b10; clause returns field 3 = 3'b101 → after absorb field 3 == 3'b101, level_o == 1, state returns to IDLE.
- Decide var 3 = 2'b10 while clause returns field 3 = 3'b111 → conflict_o == 1, conflict_var_o == 3, decide_ready_o == 0.
- From that conflict, backtrack to level 0 → fields with level ≥ 1 cleared to 0, apply_backtrack_o high exactly 1 cycle, conflict_o == 0, level_o == 0.
- Decide an already-assigned variable → handshake completes, no field change, level_o unchanged.
- Assert rst low during SETTLE → next cycle all outputs at reset values; with VAR_BASE_IMP_COUNT_EN, imp_count_o == 0.

Source files
------------

// File: rtl/var_value_base.sv
// var_value_base: per-bin variable-state store driving the clause value bus.
// Sequences decide -> settle -> absorb, keeps a decision level per variable
// and performs backtrack. Optional implied-assignment counter is enabled by
// defining VAR_BASE_IMP_COUNT_EN (adds output imp_count_o).

// Per-variable absorb decision: classifies one returned clause field
// against the base value for that variable.
module var_value_lane (
  input  logic [1:0] base_val,
  input  logic [2:0] in_f,
  output logic       conf,
  output logic       new_imp
);
  // conflict on 11 or on a value that disagrees with an assigned base;
  // an implied 01/10 on a free base becomes a new assignment
  always_comb begin
    conf    = 1'b0;
    new_imp = 1'b0;
    if (in_f[1:0] == 2'b11) begin
      conf = 1'b1;
    end else if (in_f[1:0] != 2'b00) begin
      if (base_val == 2'b00) new_imp = in_f[2];
      else if (in_f[1:0] != base_val) conf = 1'b1;
    end
  end
endmodule

module var_value_base #(
  parameter  int NUM_VARS_A_BIN = 8,
  parameter  int LEVEL_WIDTH    = 8,
  parameter  int SETTLE_CYCLES  = 2,
  localparam int IW = (NUM_VARS_A_BIN > 1) ? $clog2(NUM_VARS_A_BIN) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        load_i,
  input  logic [NUM_VARS_A_BIN*3-1:0] load_value_i,
  input  logic                        decide_valid_i,
  output logic                        decide_ready_o,
  input  logic [IW-1:0]               decide_var_i,
  input  logic [1:0]                  decide_value_i,
  output logic [NUM_VARS_A_BIN*3-1:0] var_value_toclause_o,
  input  logic [NUM_VARS_A_BIN*3-1:0] var_value_fromclause_i,
  input  logic                        backtrack_valid_i,
  input  logic [LEVEL_WIDTH-1:0]      backtrack_level_i,
  output logic                        apply_backtrack_o,
  output logic [LEVEL_WIDTH-1:0]      level_o,
  output logic                        busy_o,
  output logic                        conflict_o,
  output logic [IW-1:0]               conflict_var_o,
`ifdef VAR_BASE_IMP_COUNT_EN
  output logic [15:0]                 imp_count_o,
`endif
  output logic                        all_assigned_o
);
  localparam int N  = NUM_VARS_A_BIN;
  localparam int LW = LEVEL_WIDTH;
  localparam int S  = SETTLE_CYCLES;

  typedef enum logic [2:0] {IDLE, SETTLE, ABSORB, CONFLICT, BACKTRACK} state_t;

  state_t               state, state_nxt;
  logic [N-1:0][2:0]    fields;
  logic [N-1:0][LW-1:0] levels;
  logic [N-1:0][2:0]    from_f;
  logic [LW-1:0]        level;
  logic [LW-1:0]        level_inc;
  logic [S-1:0]         vld_pipe;
  logic [IW-1:0]        cvar;
  logic [IW-1:0]        low_conf;
  logic [N-1:0]         lane_conf, lane_new;
  logic                 any_conf, any_new;
  logic                 do_load, do_bt, do_decide, target_free;
  logic                 all_asg;

  assign from_f      = var_value_fromclause_i;
  assign any_conf    = |lane_conf;
  assign any_new     = |lane_new;
  assign target_free = (fields[decide_var_i][1:0] == 2'b00);
  assign level_inc   = (&level) ? level : level + 1'b1;

  for (genvar g = 0; g < N; g++) begin : g_lane
    var_value_lane u_lane (
      .base_val (fields[g][1:0]),
      .in_f     (from_f[g]),
      .conf     (lane_conf[g]),
      .new_imp  (lane_new[g])
    );
  end

  // lowest conflicting variable index
  always_comb begin
    low_conf = '0;
    for (int i = N - 1; i >= 0; i--)
      if (lane_conf[i]) low_conf = IW'(i);
  end

  // every variable holds a definite true/false value
  always_comb begin
    all_asg = 1'b1;
    for (int i = 0; i < N; i++)
      if (fields[i][1:0] == 2'b00 || fields[i][1:0] == 2'b11) all_asg = 1'b0;
  end

  assign var_value_toclause_o = fields;
  assign level_o              = level;
  assign busy_o               = (state != IDLE);
  assign conflict_o           = (state == CONFLICT);
  assign conflict_var_o       = cvar;
  assign apply_backtrack_o    = (state == BACKTRACK);
  assign all_assigned_o       = all_asg & ~conflict_o;
  // ready only when the decision would actually be the IDLE winner
  assign decide_ready_o       = rst & (state == IDLE) & ~load_i & ~backtrack_valid_i;

  // state register
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // next-state and action strobes
  always_comb begin
    state_nxt = state;
    do_load   = 1'b0;
    do_bt     = 1'b0;
    do_decide = 1'b0;
    case (state)
      IDLE: begin
        if (load_i) begin
          do_load   = 1'b1;
          state_nxt = SETTLE;
        end else if (backtrack_valid_i) begin
          do_bt     = 1'b1;
          state_nxt = BACKTRACK;
        end else if (decide_valid_i && target_free) begin
          do_decide = 1'b1;
          state_nxt = SETTLE;
        end
      end
      SETTLE:    if (vld_pipe[S-1]) state_nxt = ABSORB;
      ABSORB: begin
        if (any_conf)     state_nxt = CONFLICT;
        else if (any_new) state_nxt = SETTLE;
        else              state_nxt = IDLE;
      end
      CONFLICT: begin
        if (backtrack_valid_i) begin
          do_bt     = 1'b1;
          state_nxt = BACKTRACK;
        end
      end
      BACKTRACK: state_nxt = SETTLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // settle timer: a single token walks SETTLE_CYCLES stages
  always_ff @(posedge clk) begin
    if (!rst)                                      vld_pipe <= '0;
    else if (state_nxt == SETTLE && state != SETTLE) vld_pipe <= S'(1);
    else if (state == SETTLE)                      vld_pipe <= vld_pipe << 1;
    else                                           vld_pipe <= '0;
  end

`ifdef VAR_BASE_IMP_COUNT_EN
  logic [15:0] imp_count, new_cnt;
  logic [16:0] imp_sum;
  assign imp_count_o = imp_count;
  assign imp_sum     = {1'b0, imp_count} + {1'b0, new_cnt};

  // number of implied assignments this absorb cycle
  always_comb begin
    new_cnt = '0;
    for (int i = 0; i < N; i++) new_cnt = new_cnt + 16'(lane_new[i]);
  end

  // saturating implied-assignment counter
  always_ff @(posedge clk) begin
    if (!rst)                                 imp_count <= '0;
    else if (do_load)                         imp_count <= '0;
    else if (state == ABSORB && !any_conf)    imp_count <= imp_sum[16] ? 16'hFFFF : imp_sum[15:0];
  end
`endif

  // variable fields, per-variable levels, decision level, conflict index
  always_ff @(posedge clk) begin
    if (!rst) begin
      fields <= '0;
      levels <= '0;
      level  <= '0;
      cvar   <= '0;
    end else begin
      if (do_load) begin
        fields <= load_value_i;
        levels <= '0;
        level  <= '0;
      end else if (do_bt) begin
        for (int i = 0; i < N; i++) begin
          if (levels[i] > backtrack_level_i) begin
            fields[i] <= '0;
            levels[i] <= '0;
          end
        end
        level <= backtrack_level_i;
        cvar  <= '0;
      end else if (do_decide) begin
        fields[decide_var_i] <= {1'b0, decide_value_i};
        levels[decide_var_i] <= level_inc;
        level                <= level_inc;
      end else if (state == ABSORB) begin
        // a conflict suppresses the implied writes of the same cycle
        if (any_conf) begin
          cvar <= low_conf;
        end else begin
          for (int i = 0; i < N; i++) begin
            if (lane_new[i]) begin
              fields[i] <= {1'b1, from_f[i][1:0]};
              levels[i] <= level;
            end
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_var_value_base.sv
// Directed bench for var_value_base with a cycle-level reference model.
module tb_var_value_base;
  localparam int N = 8;
  localparam int S = 2;

  logic        clk, rst, load, dvalid, dready, bt_valid, apply, busy, conflict, all_asg;
  logic [23:0] load_value, toclause, fromclause;
  logic [2:0]  dvar, cvar;
  logic [1:0]  dval;
  logic [7:0]  bt_level, level;
  logic [15:0] imp_count;

  var_value_base #(.NUM_VARS_A_BIN(N), .LEVEL_WIDTH(8), .SETTLE_CYCLES(S)) dut (
    .clk(clk), .rst(rst), .load_i(load), .load_value_i(load_value),
    .decide_valid_i(dvalid), .decide_ready_o(dready), .decide_var_i(dvar),
    .decide_value_i(dval), .var_value_toclause_o(toclause),
    .var_value_fromclause_i(fromclause), .backtrack_valid_i(bt_valid),
    .backtrack_level_i(bt_level), .apply_backtrack_o(apply), .level_o(level),
    .busy_o(busy), .conflict_o(conflict), .conflict_var_o(cvar),
`ifdef VAR_BASE_IMP_COUNT_EN
    .imp_count_o(imp_count),
`endif
    .all_assigned_o(all_asg)
  );

`ifndef VAR_BASE_IMP_COUNT_EN
  assign imp_count = '0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0, failures = 0, apply_cnt = 0;
  bit live = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // m_wait: -1 none pending, k>0 settle cycles left, 0 absorb this cycle
  bit [2:0] m_f[N];
  int       m_l[N];
  int       m_level, m_wait, m_cvar, m_imp;
  bit       m_conf, m_pulse;

  function automatic logic [23:0] m_pack();
    logic [23:0] r;
    for (int i = 0; i < N; i++) r[3*i +: 3] = m_f[i];
    return r;
  endfunction

  function automatic bit m_idle();
    return !m_conf && !m_pulse && (m_wait < 0);
  endfunction

  task automatic m_backtrack(input int to);
    for (int i = 0; i < N; i++)
      if (m_l[i] > to) begin m_f[i] = 3'b000; m_l[i] = 0; end
    m_level = to;
    m_pulse = 1;
  endtask

  task automatic m_absorb();
    int first, n;
    bit [2:0] inf;
    bit nw[N];
    first = -1; n = 0;
    for (int i = 0; i < N; i++) begin
      inf = fromclause[3*i +: 3];
      nw[i] = 0;
      if (inf[1:0] == 2'b11 ||
          (inf[1:0] != 2'b00 && m_f[i][1:0] != 2'b00 && inf[1:0] != m_f[i][1:0])) begin
        if (first < 0) first = i;
      end else if (inf[2] && inf[1:0] != 2'b00 && m_f[i][1:0] == 2'b00) begin
        nw[i] = 1; n++;
      end
    end
    if (first >= 0) begin
      m_conf = 1; m_cvar = first; m_wait = -1;
    end else begin
      for (int i = 0; i < N; i++)
        if (nw[i]) begin m_f[i] = {1'b1, fromclause[3*i +: 2]}; m_l[i] = m_level; end
      m_imp  = (m_imp + n > 65535) ? 65535 : m_imp + n;
      m_wait = (n > 0) ? S : -1;
    end
  endtask

  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) begin m_f[i] = 0; m_l[i] = 0; end
      m_level = 0; m_wait = -1; m_cvar = 0; m_imp = 0; m_conf = 0; m_pulse = 0;
      live = 1;
    end else if (live) begin
      if (m_pulse) begin
        m_pulse = 0; m_wait = S;
      end else if (m_wait > 0) begin
        m_wait--;
      end else if (m_wait == 0) begin
        m_absorb();
      end else if (m_conf) begin
        if (bt_valid) begin m_backtrack(int'(bt_level)); m_conf = 0; m_cvar = 0; end
      end else if (load) begin
        for (int i = 0; i < N; i++) begin m_f[i] = load_value[3*i +: 3]; m_l[i] = 0; end
        m_level = 0; m_imp = 0; m_wait = S;
      end else if (bt_valid) begin
        m_backtrack(int'(bt_level));
      end else if (dvalid && m_f[dvar][1:0] == 2'b00) begin
        m_level = (m_level >= 255) ? 255 : m_level + 1;
        m_f[dvar] = {1'b0, dval};
        m_l[dvar] = m_level;
        m_wait = S;
      end
    end
  end

  // compare DUT against model every cycle once reset has been seen
  always @(negedge clk) begin
    if (apply === 1'b1) apply_cnt++;
    if (live) begin
      bit asg;
      asg = !m_conf;
      for (int i = 0; i < N; i++) if (m_f[i][1:0] == 2'b00 || m_f[i][1:0] == 2'b11) asg = 0;
      chk("m_toclause", toclause, m_pack());
      chk("m_level", level, m_level);
      chk("m_busy", busy, !m_idle());
      chk("m_conflict", conflict, m_conf);
      chk("m_conflict_var", cvar, m_cvar);
      chk("m_apply", apply, m_pulse);
      chk("m_ready", dready, rst && m_idle() && !load && !bt_valid);
      chk("m_all_assigned", all_asg, asg);
`ifdef VAR_BASE_IMP_COUNT_EN
      chk("m_imp_count", imp_count, m_imp);
`endif
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(negedge clk); #1;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (busy !== 1'b0 && n < 50) begin step(); n++; end
    chk(nm, busy, 0);
  endtask

  task automatic wait_conflict(input string nm);
    int n = 0;
    while (conflict !== 1'b1 && n < 50) begin step(); n++; end
    chk(nm, conflict, 1);
  endtask

  task automatic decide(input logic [2:0] v, input logic [1:0] val);
    dvalid = 1; dvar = v; dval = val;
    step();
    dvalid = 0;
  endtask

  task automatic backtrack(input logic [7:0] l);
    bt_valid = 1; bt_level = l;
    step();
    bt_valid = 0;
  endtask

  task automatic load_zero();
    load = 1; load_value = '0;
    step();
    load = 0;
  endtask

  int a0;

  initial begin
    rst = 0; load = 0; load_value = 0; dvalid = 0; dvar = 0; dval = 0;
    fromclause = 0; bt_valid = 0; bt_level = 0;
    repeat (2) step();
    chk("rst_toclause", toclause, 0);
    chk("rst_level", level, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", dready, 0);
    rst = 1;
    step();
    chk("idle_ready", dready, 1);

    load_zero();
    wait_idle("load_idle");
    chk("load_toclause", toclause, 0);
    chk("load_ready", dready, 1);

    // implied field 3 = 101 after deciding var1 = true
    fromclause = 24'h000A00;
    decide(3'd1, 2'b10);
    chk("dec_busy", busy, 1);
    wait_idle("dec_idle");
    chk("imp_toclause", toclause, 24'h000A10);
    chk("imp_level", level, 1);

    // already-assigned target: handshake only
    dvalid = 1; dvar = 3'd1; dval = 2'b01; #1;
    chk("asg_ready", dready, 1);
    step();
    dvalid = 0;
    chk("asg_busy", busy, 0);
    chk("asg_toclause", toclause, 24'h000A10);
    chk("asg_level", level, 1);

    decide(3'd0, 2'b01);
    wait_idle("dec2_idle");
    chk("dec2_toclause", toclause, 24'h000A11);
    chk("dec2_level", level, 2);

    // backtrack from IDLE to level 1 removes var0 only
    a0 = apply_cnt;
    backtrack(8'd1);
    chk("bt1_apply", apply, 1);
    wait_idle("bt1_idle");
    chk("bt1_pulses", apply_cnt - a0, 1);
    chk("bt1_toclause", toclause, 24'h000A10);
    chk("bt1_level", level, 1);

    // clause reports 111 on field 3
    fromclause = 0;
    load_zero();
    wait_idle("load2_idle");
    fromclause = 24'h000E00;
    decide(3'd3, 2'b10);
    wait_conflict("conf_wait");
    chk("conf_var", cvar, 3);
    chk("conf_ready", dready, 0);
    decide(3'd2, 2'b10);
    chk("conf_ign_toclause", toclause, 24'h000400);
    chk("conf_held", conflict, 1);

    fromclause = 0;
    a0 = apply_cnt;
    backtrack(8'd0);
    wait_idle("bt0_idle");
    chk("bt0_pulses", apply_cnt - a0, 1);
    chk("bt0_toclause", toclause, 0);
    chk("bt0_level", level, 0);
    chk("bt0_conflict", conflict, 0);

    // opposite value on 5, 111 on 6, implied on 2: conflict wins, lowest is 5
    fromclause = 24'h1F0140;
    decide(3'd5, 2'b01);
    wait_conflict("opp_wait");
    chk("opp_var", cvar, 5);
    chk("opp_toclause", toclause, 24'h008000);

    // backtrack above current level: nothing cleared, still one pulse
    fromclause = 0;
    a0 = apply_cnt;
    backtrack(8'hFF);
    wait_idle("btff_idle");
    chk("btff_pulses", apply_cnt - a0, 1);
    chk("btff_level", level, 8'hFF);
    chk("btff_toclause", toclause, 24'h008000);

    // level saturates at all-ones
    decide(3'd1, 2'b10);
    wait_idle("sat_idle");
    chk("sat_level", level, 8'hFF);
    chk("sat_toclause", toclause, 24'h008010);

    // reset while settling
    decide(3'd0, 2'b10);
    chk("rs_busy", busy, 1);
    rst = 0;
    step();
    chk("rs_toclause", toclause, 0);
    chk("rs_level", level, 0);
    chk("rs_busy0", busy, 0);
    chk("rs_ready", dready, 0);
    chk("rs_apply", apply, 0);
    chk("rs_conflict", conflict, 0);
`ifdef VAR_BASE_IMP_COUNT_EN
    chk("rs_imp_count", imp_count, 0);
`endif
    rst = 1;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
